// File: rtl/oq_dst_port_dispatch.sv
// rtl/oq_dst_port_dispatch.sv - IOQ header parse and one-hot multicast dispatch to per-port writers
module oq_dst_port_dispatch #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int NUM_QUEUES    = 8,
    parameter int IOQ_STAGE_NUM = 8'hff,
    parameter int DST_PORT_POS  = 16,
    parameter int HDR_BUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [NUM_QUEUES-1:0] out_wr,
    input  logic [NUM_QUEUES-1:0] out_rdy,
    output logic                  pkt_dispatched,
    output logic                  pkt_dropped_no_port,
    output logic                  pkt_dropped_bad_hdr
);

    localparam int PTR_W = (HDR_BUF_DEPTH > 1) ? $clog2(HDR_BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(HDR_BUF_DEPTH + 1);
    localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(IOQ_STAGE_NUM);

    typedef enum logic [1:0] {
        COLLECT_HDRS,
        FLUSH_HDRS,
        MOVE_PKT,
        DROP_PKT
    } state_t;

    state_t state;
    state_t state_next;

    // Module-header buffer; the IOQ word always lands in the last used slot
    logic [DATA_WIDTH-1:0] hdr_data [HDR_BUF_DEPTH];
    logic [CTRL_WIDTH-1:0] hdr_ctrl [HDR_BUF_DEPTH];
    logic [CNT_W-1:0]      wr_cnt;
    logic [PTR_W-1:0]      rd_ptr;

    logic [NUM_QUEUES-1:0] dst_port;
    logic                  ctrl_prev_is_0;

    logic                  accept;
    logic                  eop;
    logic                  is_ioq;
    logic                  is_data;
    logic                  ports_ok;
    logic                  buf_full;
    logic                  hdr_last_slot;
    logic                  pop_last;
    logic [NUM_QUEUES-1:0] in_dst;

    logic                  push;
    logic                  pop;
    logic                  clr;
    logic                  fwd;
    logic                  latch_dst;

    assign accept        = in_wr && in_rdy;
    assign eop           = ctrl_prev_is_0 && (in_ctrl != '0);
    assign is_ioq        = (in_ctrl == IOQ_CTRL);
    assign is_data       = (in_ctrl == '0);
    assign ports_ok      = ((out_rdy & dst_port) == dst_port);
    assign buf_full      = (wr_cnt == CNT_W'(HDR_BUF_DEPTH));
    assign hdr_last_slot = (wr_cnt == CNT_W'(HDR_BUF_DEPTH - 1));
    assign pop_last      = ((CNT_W'(rd_ptr) + CNT_W'(1)) == wr_cnt);
    assign in_dst        = in_data[DST_PORT_POS +: NUM_QUEUES];

    // Input readiness: a word only moves when every selected port can take it
    always_comb begin
        in_rdy = 1'b0;
        case (state)
            COLLECT_HDRS: in_rdy = !buf_full;
            FLUSH_HDRS:   in_rdy = 1'b0;
            MOVE_PKT:     in_rdy = ports_ok;
            DROP_PKT:     in_rdy = 1'b1;
            default:      in_rdy = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT_HDRS;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, datapath strobes and drop/dispatch pulses
    always_comb begin
        state_next          = state;
        push                = 1'b0;
        pop                 = 1'b0;
        clr                 = 1'b0;
        fwd                 = 1'b0;
        latch_dst           = 1'b0;
        pkt_dispatched      = 1'b0;
        pkt_dropped_no_port = 1'b0;
        pkt_dropped_bad_hdr = 1'b0;
        case (state)
            COLLECT_HDRS: begin
                if (accept) begin
                    if (is_ioq) begin
                        latch_dst = 1'b1;
                        if (in_dst != '0) begin
                            push       = 1'b1;
                            state_next = FLUSH_HDRS;
                        end else begin
                            pkt_dropped_no_port = 1'b1;
                            clr                 = 1'b1;
                            state_next          = DROP_PKT;
                        end
                    end else if (is_data || hdr_last_slot) begin
                        // Payload before the IOQ header, or no slot left for it
                        pkt_dropped_bad_hdr = 1'b1;
                        clr                 = 1'b1;
                        state_next          = DROP_PKT;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            FLUSH_HDRS: begin
                if (ports_ok) begin
                    pop = 1'b1;
                    if (pop_last) begin
                        state_next = MOVE_PKT;
                    end
                end
            end
            MOVE_PKT: begin
                if (accept) begin
                    fwd = 1'b1;
                    if (eop) begin
                        pkt_dispatched = 1'b1;
                        state_next     = COLLECT_HDRS;
                    end
                end
            end
            DROP_PKT: begin
                if (accept && eop) begin
                    state_next = COLLECT_HDRS;
                end
            end
            default: state_next = COLLECT_HDRS;
        endcase
    end

    // Header buffer storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            hdr_data[wr_cnt[PTR_W-1:0]] <= in_data;
            hdr_ctrl[wr_cnt[PTR_W-1:0]] <= in_ctrl;
        end
    end

    // Buffer pointers, destination latch, eop tracking and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt         <= '0;
            rd_ptr         <= '0;
            dst_port       <= '0;
            ctrl_prev_is_0 <= 1'b0;
            out_wr         <= '0;
            out_data       <= '0;
            out_ctrl       <= '0;
        end else begin
            out_wr <= '0;
            if (accept) begin
                ctrl_prev_is_0 <= is_data;
            end
            if (latch_dst) begin
                dst_port <= in_dst;
            end
            if (clr || (pop && pop_last)) begin
                wr_cnt <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            if (pop) begin
                out_data <= hdr_data[rd_ptr];
                out_ctrl <= hdr_ctrl[rd_ptr];
                out_wr   <= dst_port;
            end else if (fwd) begin
                out_data <= in_data;
                out_ctrl <= in_ctrl;
                out_wr   <= dst_port;
            end
        end
    end

endmodule

// File: tb/tb_oq_dst_port_dispatch.sv
// tb/tb_oq_dst_port_dispatch.sv - directed self-checking bench for oq_dst_port_dispatch
module tb_oq_dst_port_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [7:0]  out_wr;
    logic [7:0]  out_rdy;
    logic        pkt_dispatched;
    logic        pkt_dropped_no_port;
    logic        pkt_dropped_bad_hdr;

    int tests = 0;
    int fails = 0;
    int multi_pulse = 0;
    int last_waits;
    logic [2:0] last_pulses;

    logic [79:0] cap_q[$];
    logic [79:0] exp_q[$];

    oq_dst_port_dispatch dut (
        .clk                 (clk),
        .reset               (reset),
        .in_data             (in_data),
        .in_ctrl             (in_ctrl),
        .in_wr               (in_wr),
        .in_rdy              (in_rdy),
        .out_data            (out_data),
        .out_ctrl            (out_ctrl),
        .out_wr              (out_wr),
        .out_rdy             (out_rdy),
        .pkt_dispatched      (pkt_dispatched),
        .pkt_dropped_no_port (pkt_dropped_no_port),
        .pkt_dropped_bad_hdr (pkt_dropped_bad_hdr)
    );

    always #5 clk = ~clk;

    // Record every output write and watch for overlapping pulses
    always @(negedge clk) begin
        if (out_wr != 8'h00) cap_q.push_back({out_wr, out_data, out_ctrl});
        if ($countones({pkt_dispatched, pkt_dropped_no_port, pkt_dropped_bad_hdr}) > 1)
            multi_pulse++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word from posedge+2, hold until accepted, return at posedge+2
    task automatic put(input logic [63:0] d, input logic [7:0] c);
        logic done;
        done = 1'b0;
        in_data = d;
        in_ctrl = c;
        in_wr = 1'b1;
        last_waits = 0;
        last_pulses = 3'b000;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                last_pulses = {pkt_dispatched, pkt_dropped_no_port, pkt_dropped_bad_hdr};
                done = 1'b1;
            end else begin
                last_waits++;
            end
            @(posedge clk);
            #2;
        end
        in_wr = 1'b0;
        if (!done) check("put_timeout", 80'(done), 80'(1));
    endtask

    task automatic tx(input logic [63:0] d, input logic [7:0] c, input logic [7:0] expw);
        if (expw != 8'h00) exp_q.push_back({expw, d, c});
        put(d, c);
    endtask

    task automatic cmp_out(input string tag);
        repeat (2) @(posedge clk);
        #2;
        check({tag, "_count"}, 80'(cap_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check(tag, cap_q[i], exp_q[i]);
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        in_wr = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_rdy = 8'hff;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_wr", 80'(out_wr), 80'(0));
        check("rst_out_data", 80'(out_data), 80'(0));
        check("rst_out_ctrl", 80'(out_ctrl), 80'(0));
        check("rst_pulses", 80'({pkt_dispatched, pkt_dropped_no_port, pkt_dropped_bad_hdr}), 80'(0));
        check("rst_in_rdy", 80'(in_rdy), 80'(1));
        @(posedge clk);
        #2;

        // Unicast: one module header, IOQ to port 2, three data words
        tx(64'h1111_2222_3333_4444, 8'h01, 8'h04);
        tx(64'hab00_0000_0004_00cd, 8'hff, 8'h04);
        tx(64'h0000_0000_0000_00d0, 8'h00, 8'h04);
        check("uni_flush_cycles", 80'(last_waits), 80'(2));
        tx(64'h0000_0000_0000_00d1, 8'h00, 8'h04);
        tx(64'h0000_0000_0000_00d2, 8'h04, 8'h04);
        check("uni_eop_pulse", 80'(last_pulses), 80'(3'b100));
        cmp_out("uni");

        // Multicast to ports 0 and 6 with port 6 stalled mid-payload
        tx(64'h0000_0000_0041_0000, 8'hff, 8'h41);
        tx(64'h0000_0000_0000_00e0, 8'h00, 8'h41);
        check("mc_flush_cycles", 80'(last_waits), 80'(1));
        tx(64'h0000_0000_0000_00e1, 8'h00, 8'h41);
        out_rdy = 8'hbf;
        in_data = 64'h0000_0000_0000_00e2;
        in_ctrl = 8'h00;
        in_wr = 1'b1;
        @(negedge clk);
        check("mc_stall_rdy0", 80'(in_rdy), 80'(0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            @(negedge clk);
            check("mc_stall_rdy", 80'(in_rdy), 80'(0));
            check("mc_stall_wr", 80'(out_wr), 80'(0));
        end
        @(posedge clk);
        #2;
        out_rdy = 8'hff;
        tx(64'h0000_0000_0000_00e2, 8'h00, 8'h41);
        tx(64'h0000_0000_0000_00e3, 8'h02, 8'h41);
        check("mc_eop_pulse", 80'(last_pulses), 80'(3'b100));
        cmp_out("mc");

        // IOQ with no destination, then a normal packet to port 1
        tx(64'h0000_0000_0000_0000, 8'hff, 8'h00);
        check("np_pulse", 80'(last_pulses), 80'(3'b010));
        tx(64'h0000_0000_0000_00f0, 8'h00, 8'h00);
        tx(64'h0000_0000_0000_00f1, 8'h03, 8'h00);
        check("np_eop_nopulse", 80'(last_pulses), 80'(3'b000));
        tx(64'h0000_0000_0002_0000, 8'hff, 8'h02);
        tx(64'h0000_0000_0000_00a0, 8'h00, 8'h02);
        tx(64'h0000_0000_0000_00a1, 8'h01, 8'h02);
        check("np_next_pulse", 80'(last_pulses), 80'(3'b100));
        cmp_out("np");

        // Payload before any IOQ header
        tx(64'h0000_0000_0000_0bad, 8'h00, 8'h00);
        check("bh_pulse", 80'(last_pulses), 80'(3'b001));
        tx(64'h0000_0000_0000_0bae, 8'h00, 8'h00);
        tx(64'h0000_0000_0000_0baf, 8'h01, 8'h00);
        check("bh_eop_nopulse", 80'(last_pulses), 80'(3'b000));
        cmp_out("bh");

        // Header overflow: fourth non-IOQ header word is dropped
        tx(64'h0000_0000_0000_0c01, 8'h01, 8'h00);
        tx(64'h0000_0000_0000_0c02, 8'h02, 8'h00);
        tx(64'h0000_0000_0000_0c03, 8'h03, 8'h00);
        check("ov_third_nopulse", 80'(last_pulses), 80'(3'b000));
        tx(64'h0000_0000_0000_0c04, 8'h04, 8'h00);
        check("ov_pulse", 80'(last_pulses), 80'(3'b001));
        tx(64'h0000_0000_0000_0c05, 8'h00, 8'h00);
        tx(64'h0000_0000_0000_0c06, 8'h05, 8'h00);
        cmp_out("ov");

        // Reset in the middle of MOVE_PKT, then a clean packet
        tx(64'h0000_0000_0008_0000, 8'hff, 8'h08);
        tx(64'h0000_0000_0000_0d00, 8'h00, 8'h08);
        reset = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        check("mr_out_wr", 80'(out_wr), 80'(0));
        check("mr_out_data", 80'(out_data), 80'(0));
        check("mr_out_ctrl", 80'(out_ctrl), 80'(0));
        @(posedge clk);
        #2;
        reset = 1'b0;
        tx(64'h5555_6666_7777_8888, 8'h01, 8'h10);
        tx(64'h0000_0000_0010_0000, 8'hff, 8'h10);
        tx(64'h0000_0000_0000_0d10, 8'h00, 8'h10);
        check("mr_flush_cycles", 80'(last_waits), 80'(2));
        tx(64'h0000_0000_0000_0d11, 8'h08, 8'h10);
        check("mr_eop_pulse", 80'(last_pulses), 80'(3'b100));
        cmp_out("mr");

        check("pulse_exclusive", 80'(multi_pulse), 80'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
